// File: rtl/mac_row_sequencer_if.sv
// Sequencer-side bundle: memory read port, MAC operand/control/result taps, and the row result stream.
// The master modport is the sequencer; the slave modport is the memories, MAC and result consumer.
interface mac_row_sequencer_if #(
   parameter int M  = 4,
   parameter int K  = 8,
   parameter int DW = 14,
   parameter int AW = 28
);
   localparam int WAW = (M * K > 1) ? $clog2(M * K) : 1;
   localparam int XAW = (K > 1) ? $clog2(K) : 1;
   localparam int YIW = (M > 1) ? $clog2(M) : 1;

   logic [WAW-1:0]       w_addr;
   logic [XAW-1:0]       x_addr;
   logic                 mem_en;
   logic signed [DW-1:0] w_rdata;
   logic signed [DW-1:0] x_rdata;
   logic signed [DW-1:0] mac_a;
   logic signed [DW-1:0] mac_b;
   logic                 mac_valid_in;
   logic                 mac_clear;
   logic                 mac_valid_out;
   logic signed [AW-1:0] mac_f;
   logic                 y_valid;
   logic                 y_ready;
   logic signed [AW-1:0] y_data;
   logic [YIW-1:0]       y_index;

   modport master (
      output w_addr, x_addr, mem_en, mac_a, mac_b, mac_valid_in, mac_clear,
             y_valid, y_data, y_index,
      input  w_rdata, x_rdata, mac_valid_out, mac_f, y_ready
   );

   modport slave (
      input  w_addr, x_addr, mem_en, mac_a, mac_b, mac_valid_in, mac_clear,
             y_valid, y_data, y_index,
      output w_rdata, x_rdata, mac_valid_out, mac_f, y_ready
   );
endinterface

// File: rtl/mac_row_sequencer.sv
// Drives an external pipelined MAC through M rows of K-term dot products, one row at a time.
// Optional macro SEQ_RELU_EN clamps negative row results to zero before they are presented.
module mac_row_sequencer #(
   parameter int M       = 4,
   parameter int K       = 8,
   parameter int DW      = 14,
   parameter int AW      = 28,
   parameter int CLR_CYC = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   mac_row_sequencer_if.master bus
);
   localparam int WAW = (M * K > 1) ? $clog2(M * K) : 1;
   localparam int XAW = (K > 1) ? $clog2(K) : 1;
   localparam int YIW = (M > 1) ? $clog2(M) : 1;
   localparam int CCW = $clog2(CLR_CYC + 1);
   localparam int RCW = $clog2(K + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_OUT,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [YIW-1:0]       r_row;
   logic [XAW-1:0]       r_col;
   logic [CCW-1:0]       r_clr_cnt;
   logic [RCW-1:0]       r_ret_cnt;
   logic                 r_mac_valid_in;
   logic signed [AW-1:0] r_y_data;
   logic [YIW-1:0]       r_y_index;

   logic                 w_clr_last;
   logic                 w_feed_last;
   logic                 w_row_last;
   logic                 w_ret_inc;
   logic [RCW-1:0]       w_ret_nxt;
   logic                 w_ret_full;
   logic signed [AW-1:0] w_y_cap;
   logic [WAW-1:0]       w_w_addr;

   assign w_clr_last  = (r_clr_cnt == CCW'(CLR_CYC - 1));
   assign w_feed_last = (r_col == XAW'(K - 1));
   assign w_row_last  = (r_row == YIW'(M - 1));

   // Return counter saturates at K so stray pulses can never wrap it back below the finish line.
   assign w_ret_inc  = bus.mac_valid_out && (r_ret_cnt != RCW'(K));
   assign w_ret_nxt  = r_ret_cnt + RCW'(w_ret_inc);
   assign w_ret_full = (w_ret_nxt == RCW'(K));

`ifdef SEQ_RELU_EN
   assign w_y_cap = bus.mac_f[AW-1] ? '0 : bus.mac_f;
`else
   assign w_y_cap = bus.mac_f;
`endif

   assign w_w_addr = WAW'(r_row) * WAW'(K) + WAW'(r_col);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      busy          = 1'b1;
      done          = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mac_clear = 1'b0;
      bus.y_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            bus.mac_clear = 1'b1;
            if (w_clr_last) begin
               w_state_nxt = S_FEED;
            end
         end
         S_FEED: begin
            bus.mem_en = 1'b1;
            if (w_feed_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_ret_full) begin
               w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            bus.y_valid = 1'b1;
            if (bus.y_ready) begin
               w_state_nxt = w_row_last ? S_DONE : S_CLEAR;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_row          <= '0;
         r_col          <= '0;
         r_clr_cnt      <= '0;
         r_ret_cnt      <= '0;
         r_mac_valid_in <= 1'b0;
         r_y_data       <= '0;
         r_y_index      <= '0;
      end else begin
         r_mac_valid_in <= bus.mem_en;
         r_clr_cnt      <= (r_state == S_CLEAR) ? r_clr_cnt + 1'b1 : '0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_row <= '0;
               end
            end
            S_CLEAR: begin
               r_col     <= '0;
               r_ret_cnt <= '0;
            end
            S_FEED: begin
               r_col     <= r_col + 1'b1;
               r_ret_cnt <= w_ret_nxt;
            end
            S_DRAIN: begin
               r_ret_cnt <= w_ret_nxt;
               if (w_ret_full) begin
                  r_y_data  <= w_y_cap;
                  r_y_index <= r_row;
               end
            end
            S_OUT: begin
               if (bus.y_ready && !w_row_last) begin
                  r_row <= r_row + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Addresses read as zero outside FEED so an idle memory bus carries no stale row pointer.
   assign bus.w_addr       = bus.mem_en ? w_w_addr : '0;
   assign bus.x_addr       = bus.mem_en ? r_col : '0;
   assign bus.mac_a        = bus.w_rdata;
   assign bus.mac_b        = bus.x_rdata;
   assign bus.mac_valid_in = r_mac_valid_in;
   assign bus.y_data       = r_y_data;
   assign bus.y_index      = r_y_index;

endmodule
